// File: rtl/reg_share_pkg.sv
// Shared types and helpers for the round-robin register-sharing arbiter.
package reg_share_pkg;

  localparam int MAX_REQ     = 8;
  localparam int N_REQ_DEF   = 4;
  localparam int DW_DEF      = 8;
  localparam int HOLD_MAX_DEF = 4;
  localparam int IDX_W       = $clog2(N_REQ_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    onehot = 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Rotating priority encoder: first eligible request at or above base, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  input  logic [N-1:0]  excl,
  output logic [IW-1:0] winner,
  output logic          found
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          hit;

  // Scan N positions starting at base; the first eligible one wins
  always_comb begin
    winner = {IW{1'b0}};
    found  = 1'b0;
    sum    = {(IW+1){1'b0}};
    idx    = {IW{1'b0}};
    hit    = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum    = {1'b0, base} + (IW+1)'(k);
      idx    = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
      hit    = req[idx] & ~excl[idx] & ~found;
      winner = hit ? idx : winner;
      found  = found | hit;
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin owner of a shared DW-bit register; the granted requester writes it
// every cycle it keeps its request up, and a hold limit forces rotation.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int DW       = DW_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      wdata,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic [DW-1:0]            q,
  output logic                     q_valid
);

  localparam int IW   = $clog2(N_REQ);
  localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  state_t          state, state_n;
  logic [IW-1:0]   rr_ptr, rr_ptr_n;
  logic [HC_W-1:0] hold_cnt, hold_cnt_n;
  logic [N_REQ-1:0] grant_n, excl;
  logic [IW-1:0]   owner_n, winner, winner_inc;
  logic            found, owner_req, hold_last, we;
  logic [DW-1:0]   wsel;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (req),
    .base   (rr_ptr),
    .excl   (excl),
    .winner (winner),
    .found  (found)
  );

  // Arbitration inputs and the selected write lane
  always_comb begin
    owner_req  = req[owner];
    hold_last  = (hold_cnt == HC_W'(HOLD_MAX-1));
    excl       = (state == BUSY) ? N_REQ'(onehot(3'(owner))) : {N_REQ{1'b0}};
    winner_inc = (winner == IW'(N_REQ-1)) ? {IW{1'b0}} : winner + IW'(1);
    we         = |(grant & req);
    wsel       = {DW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      wsel = grant[i] ? wdata[i*DW +: DW] : wsel;
    end
  end

  // Next-state: grant, rotate on release or hold expiry, otherwise count hold
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    owner_n    = owner;
    rr_ptr_n   = rr_ptr;
    hold_cnt_n = hold_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_n    = BUSY;
          grant_n    = N_REQ'(onehot(3'(winner)));
          owner_n    = winner;
          rr_ptr_n   = winner_inc;
          hold_cnt_n = {HC_W{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (!owner_req || hold_last) begin
          if (found) begin
            grant_n    = N_REQ'(onehot(3'(winner)));
            owner_n    = winner;
            rr_ptr_n   = winner_inc;
            hold_cnt_n = {HC_W{1'b0}};
          end else if (!owner_req) begin
            state_n    = IDLE;
            grant_n    = {N_REQ{1'b0}};
            hold_cnt_n = {HC_W{1'b0}};
          end else begin
            // sole requester at the limit keeps the grant and restarts its count
            hold_cnt_n = {HC_W{1'b0}};
          end
        end else begin
          hold_cnt_n = hold_cnt + HC_W'(1);
        end
      end
      default: begin
        state_n    = IDLE;
        grant_n    = {N_REQ{1'b0}};
        hold_cnt_n = {HC_W{1'b0}};
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= {N_REQ{1'b0}};
      owner    <= {IW{1'b0}};
      rr_ptr   <= {IW{1'b0}};
      hold_cnt <= {HC_W{1'b0}};
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  // Shared storage register, written only by a granted requester still requesting
  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= {DW{1'b0}};
      q_valid <= 1'b0;
    end else if (we) begin
      q       <= wsel;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter (N_REQ=4, DW=8, HOLD_MAX=4).
module tb_reg_share_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        q_valid;

  int total;
  int passed;
  int failed;

  reg_share_arbiter #(.N_REQ(4), .DW(8), .HOLD_MAX(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wdata   (wdata),
    .grant   (grant),
    .owner   (owner),
    .q       (q),
    .q_valid (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    reset  = 1'b1;
    req    = 4'b0000;
    wdata  = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_q", 32'(q), 32'h0);
    check("rst_qv", 32'(q_valid), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);

    // idle for 10 cycles
    repeat (10) tick();
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_q", 32'(q), 32'h0);
    check("idle_qv", 32'(q_valid), 32'h0);
    check("idle_owner", 32'(owner), 32'h0);

    // single requester on lane 2
    wdata = 32'h13A5_1110;
    req   = 4'b0100;
    tick();
    check("single_grant", 32'(grant), 32'h4);
    check("single_owner", 32'(owner), 32'h2);
    check("single_qv_early", 32'(q_valid), 32'h0);
    tick();
    check("single_q", 32'(q), 32'hA5);
    check("single_qv", 32'(q_valid), 32'h1);
    tick();
    req = 4'b0000;
    tick();
    check("single_release_grant", 32'(grant), 32'h0);
    check("single_hold_q", 32'(q), 32'hA5);

    // full contention: owners 0,1,2,3,0 for exactly 4 cycles each
    do_reset();
    wdata = 32'h1312_1110;
    req   = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        check("rot_grant", 32'(grant), 32'(4'b0001 << (r % 4)));
        check("rot_owner", 32'(owner), 32'(r % 4));
        if (c != 0) begin
          check("rot_q", 32'(q), 32'(8'h10 + 8'(r % 4)));
        end
      end
    end

    // release handover 1 -> 3 with no idle gap and no write in the release cycle
    do_reset();
    wdata = 32'h3322_1100;
    req   = 4'b1010;
    tick();
    check("ho_grant1", 32'(grant), 32'h2);
    tick();
    check("ho_q1", 32'(q), 32'h11);
    req   = 4'b1000;
    wdata = 32'h3322_7700;
    tick();
    check("ho_grant3", 32'(grant), 32'h8);
    check("ho_owner3", 32'(owner), 32'h3);
    check("ho_no_write", 32'(q), 32'h11);
    tick();
    check("ho_q3", 32'(q), 32'h33);

    // lone holder beyond the hold limit keeps the grant and writes every cycle
    do_reset();
    req   = 4'b0001;
    wdata = 32'h0000_0040;
    tick();
    check("lone_grant0", 32'(grant), 32'h1);
    check("lone_q0", 32'(q), 32'h0);
    for (int i = 1; i <= 12; i++) begin
      wdata[7:0] = 8'h40 + 8'(i);
      tick();
      check("lone_grant", 32'(grant), 32'h1);
      check("lone_q", 32'(q), 32'(8'h40 + 8'(i)));
    end

    // reset in the middle of a grant
    do_reset();
    req   = 4'b0100;
    wdata = 32'h005A_0000;
    tick();
    tick();
    check("mid_owner", 32'(owner), 32'h2);
    check("mid_q", 32'(q), 32'h5A);
    reset = 1'b1;
    tick();
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_q", 32'(q), 32'h0);
    check("mid_rst_qv", 32'(q_valid), 32'h0);
    check("mid_rst_owner", 32'(owner), 32'h0);
    reset = 1'b0;
    tick();
    check("mid_regrant", 32'(grant), 32'h4);
    tick();
    check("mid_q_again", 32'(q), 32'h5A);
    check("mid_qv_again", 32'(q_valid), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
